// File: rtl/serial_frame_rx.sv
// Framed LSB-first serial receiver: start, data, optional parity, stop.
// Good words are held in a one-deep valid/ready output register.
module serial_frame_rx #(
  parameter int DATA_W     = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              s_din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;

  logic w_consume;
  logic w_par_bad;

  assign w_consume = r_valid & dout_ready;
  assign w_par_bad = PARITY_EN &&
                     ((^r_shift ^ r_par) != PARITY_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (w_consume)
        r_valid <= 1'b0;
      if (bit_en) begin
        unique case (r_state)
          S_IDLE: begin
            if (!s_din) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {s_din, r_shift[DATA_W-1:1]};
            r_cnt   <= r_cnt + ONE;
            if (r_cnt == LAST)
              r_state <= PARITY_EN ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            r_par   <= s_din;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            // Error priority: framing, then parity, then overrun.
            if (!s_din)
              r_ferr <= 1'b1;
            else if (w_par_bad)
              r_perr <= 1'b1;
            else if (r_valid && !dout_ready)
              r_ovr <= 1'b1;
            else begin
              r_dout  <= r_shift;
              r_valid <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: cycle table, directed corner
// sequences and a randomized frame-level scoreboard.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       s_din;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors;
  int miscompares;

  serial_frame_rx #(
    .DATA_W(4),
    .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bit_en(bit_en),
    .s_din(s_din),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       en;
    logic       din;
    logic       rdy;
    logic [4:0] f;
    logic [3:0] d;
    logic       cd;
  } vec_t;

  vec_t tbl[$];

  logic       m_pend;
  logic [3:0] m_word;

  function automatic void add(logic r, logic en, logic din,
                              logic rdy, logic [4:0] f,
                              logic [3:0] d, logic cd);
    vec_t v;
    v.r = r; v.en = en; v.din = din; v.rdy = rdy;
    v.f = f; v.d = d; v.cd = cd;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e,
               $time);
    end
  endtask

  task automatic step(input logic en, input logic din);
    bit_en = en;
    s_din  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic gapc(input int n);
    repeat (n) step(1'b0, ~s_din);
  endtask

  function automatic logic [7:0] flags();
    return {3'b0, dout_valid, parity_err, frame_err, overrun,
            busy};
  endfunction

  // Start, 4 data bits, even parity (optionally flipped), stop.
  task automatic frame(input logic [3:0] d, input logic pflip,
                       input logic stop, input int gap,
                       input logic rs);
    logic [5:0] b;
    logic       r0;
    b = {(^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 6; i++) begin
      gapc(gap);
      step(1'b1, b[i]);
    end
    gapc(gap);
    r0 = dout_ready;
    dout_ready = rs;
    step(1'b1, stop);
    dout_ready = r0;
  endtask

  // Random-phase bit with scoreboard update.
  task automatic rbit(input logic en, input logic din,
                      input logic last, input logic [3:0] d,
                      input logic pb);
    logic epe, efe, eov, load;
    dout_ready = 1'($urandom);
    epe = 1'b0; efe = 1'b0; eov = 1'b0; load = 1'b0;
    if (last) begin
      if (!din) efe = 1'b1;
      else if (((^d) ^ pb) != 1'b0) epe = 1'b1;
      else if (m_pend && !dout_ready) eov = 1'b1;
      else load = 1'b1;
    end
    if (load) begin
      m_pend = 1'b1;
      m_word = d;
    end else if (m_pend && dout_ready) begin
      m_pend = 1'b0;
    end
    step(en, din);
    chk("rnd_flags", {5'b0, parity_err, frame_err, overrun},
        {5'b0, epe, efe, eov});
    chk("rnd_valid", {7'b0, dout_valid}, {7'b0, m_pend});
    if (m_pend)
      chk("rnd_dout", {4'b0, dout}, {4'b0, m_word});
  endtask

  initial begin
    logic [3:0] d;
    logic [5:0] b;
    logic       stop, pflip, pb;
    int         kind, gap;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bit_en = 1'b0;
    s_din = 1'b1;
    dout_ready = 1'b1;

    // flags column: {valid, parity_err, frame_err, overrun, busy}
    add(1, 0, 1, 1, 5'b00000, 4'h0, 1);
    add(0, 1, 1, 1, 5'b00000, 4'h0, 0);
    add(0, 0, 0, 1, 5'b00000, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b10000, 4'hA, 1);
    add(0, 1, 1, 1, 5'b00000, 4'h0, 0);
    // parity error on 4'hA
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b01000, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00000, 4'h0, 0);
    // good 4'h3
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b10000, 4'h3, 1);
    add(0, 1, 1, 1, 5'b00000, 4'h0, 0);
    // framing error on 4'hA
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00001, 4'h0, 0);
    add(0, 1, 0, 1, 5'b00100, 4'h0, 0);
    add(0, 1, 1, 1, 5'b00000, 4'h0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      dout_ready = tbl[i].rdy;
      step(tbl[i].en, tbl[i].din);
      chk($sformatf("tbl%0d_flags", i), flags(),
          {3'b0, tbl[i].f});
      if (tbl[i].cd)
        chk($sformatf("tbl%0d_dout", i), {4'b0, dout},
            {4'b0, tbl[i].d});
    end
    rst = 1'b0;

    // Backpressure, overrun, consume coinciding with new load
    dout_ready = 1'b0;
    frame(4'h5, 1'b0, 1'b1, 0, 1'b0);
    chk("bp_first", flags(), 8'b0001_0000);
    chk("bp_first_d", {4'b0, dout}, 8'h05);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("bp_hold", flags(), 8'b0001_0000);
    frame(4'hC, 1'b0, 1'b1, 0, 1'b0);
    chk("ovr_flag", flags(), 8'b0001_0010);
    chk("ovr_dout", {4'b0, dout}, 8'h05);
    step(1'b1, 1'b1);
    chk("ovr_pulse", flags(), 8'b0001_0000);
    dout_ready = 1'b1;
    step(1'b1, 1'b1);
    dout_ready = 1'b0;
    chk("consume", flags(), 8'b0000_0000);
    frame(4'h6, 1'b0, 1'b1, 0, 1'b0);
    chk("reload_d", {4'b0, dout}, 8'h06);
    frame(4'h9, 1'b0, 1'b1, 0, 1'b1);
    chk("swap_flags", flags(), 8'b0001_0000);
    chk("swap_dout", {4'b0, dout}, 8'h09);
    dout_ready = 1'b1;
    step(1'b1, 1'b1);
    chk("swap_drain", flags(), 8'b0000_0000);

    // Sparse strobe: bit_en every third cycle
    frame(4'h9, 1'b0, 1'b1, 2, 1'b1);
    chk("sparse_flags", flags(), 8'b0001_0000);
    chk("sparse_dout", {4'b0, dout}, 8'h09);
    step(1'b1, 1'b1);

    // Reset after two data bits
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("mid_busy", flags(), 8'b0000_0001);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    chk("mid_rst", flags(), 8'b0000_0000);
    step(1'b1, 1'b1);
    chk("mid_after", flags(), 8'b0000_0000);
    frame(4'hF, 1'b0, 1'b1, 0, 1'b1);
    chk("post_rst_f", flags(), 8'b0001_0000);
    chk("post_rst_d", {4'b0, dout}, 8'h0F);

    // Randomized frames against the scoreboard
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    m_pend = 1'b0;
    m_word = 4'h0;
    for (int n = 0; n < 40; n++) begin
      d = 4'($urandom);
      kind = int'($urandom_range(0, 5));
      stop = (kind != 0);
      pflip = (kind == 1);
      pb = (^d) ^ pflip;
      gap = int'($urandom_range(0, 2));
      b = {pb, d, 1'b0};
      repeat ($urandom_range(0, 2))
        rbit(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        repeat (gap) rbit(1'b0, 1'($urandom), 1'b0, 4'h0, 1'b0);
        rbit(1'b1, b[i], 1'b0, 4'h0, 1'b0);
      end
      repeat (gap) rbit(1'b0, 1'($urandom), 1'b0, 4'h0, 1'b0);
      rbit(1'b1, stop, 1'b1, d, pb);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial receive stage that feeds the 4-bit universal shift register's parallel-load path.
- Takes a framed, LSB-first serial bit stream: start bit, DATA_W data bits, optional parity bit, stop bit.
- Checks framing and parity, then presents each good word on a one-deep valid/ready output register.
- Downstream loads the word with select=3.

Parameters:
DATA_W, 4, data bits per frame; also the width of dout
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
bit_en  input  1  bit strobe; s_din is sampled only in cycles where bit_en=1
s_din  input  1  serial data in; idle level 1
dout  output  DATA_W  received word, LSB = first data bit received
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  downstream accepts dout when dout_valid=1 and dout_ready=1
parity_err  output  1  one-cycle pulse: frame dropped for bad parity
frame_err  output  1  one-cycle pulse: frame dropped, stop bit sampled as 0
overrun  output  1  one-cycle pulse: good frame dropped because the output register was full
busy  output  1  high in every state except IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain. Every register updates only on rising clk.
  - rst is synchronous and active-high.
  - Reset values: state=IDLE, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame. No flag pulses and no partial word are emitted.
- Bit sampling:
  - All state/counter/shift updates happen only in cycles with bit_en=1.
  - With bit_en=0, everything holds, except the output-handshake logic and the one-cycle pulse clearing.
- States (transitions on bit_en=1 cycles):
  - IDLE: s_din=0 (start bit) -> DATA, bit counter=0. s_din=1 -> stay in IDLE.
  - DATA: shift s_din in LSB-first (right shift, new bit enters the MSB). Increment counter. After the DATA_W-th bit go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: capture s_din as the parity bit -> STOP.
  - STOP: evaluate the frame, then return to IDLE. No start bit is accepted in this same cycle; the next start bit is taken on a later bit_en.
- Frame evaluation in the STOP cycle, in priority order:
  1. s_din=0: frame_err pulses the next cycle; word dropped.
  2. Parity mismatch: parity_err pulses the next cycle; word dropped.
     - Even parity: the XOR of data and parity bits must be 0.
     - Odd parity: that XOR must be 1.
  3. Output register full and not being consumed this cycle: overrun pulses the next cycle. The new word is dropped; dout keeps the old word and dout_valid stays 1.
  4. Otherwise: dout loads the word and dout_valid=1 from the next cycle.
- Latency: dout_valid rises exactly 1 clk after the clk edge that samples the stop bit.
- Output handshake:
  - A cycle with dout_valid=1 and dout_ready=1 consumes the word. dout_valid falls next cycle unless a new good word loads in that same cycle.
  - Consume and new-word load in the same cycle: no overrun; the new word replaces the old and dout_valid stays 1.
  - dout is stable while dout_valid=1 and not consumed.
  - dout_ready is ignored while dout_valid=0.
  - After a consume, dout keeps its last value (don't-care).
- Flags: parity_err, frame_err and overrun are single-cycle pulses. At most one of them pulses per frame.
- Widths: counter is $clog2(DATA_W+1) bits and must never wrap within a frame.

Test Plan:
- Good frame (DATA_W=4, even parity, bit_en every cycle, dout_ready=1): s_din = 1, 0(start), 0,1,0,1, 0(par), 1(stop) -> dout=4'hA, dout_valid high for 1 cycle, exactly 1 clk after the stop-sample edge; all flags 0.
- Parity error: same frame with parity bit 1 -> parity_err one-cycle pulse; dout_valid stays 0; the next good frame 4'h3 (bits 1,1,0,0, par 0, stop 1) is received correctly.
- Framing error: 4'hA frame with stop bit 0 -> frame_err pulse only, no dout_valid; receiver back in IDLE (busy=0).
- Backpressure and overrun, dout_ready=0:
  - Frame 4'h5 -> dout=4'h5, dout_valid=1.
  - Second frame 4'hC -> overrun pulse; dout stays 4'h5.
  - Raise dout_ready for 1 cycle -> dout_valid falls.
  - A third frame completing in the same cycle as the consume -> no overrun; dout takes the new word.
- Sparse strobe: bit_en high every 3rd cycle, s_din toggling between strobes -> 4'h9 received; values on non-strobe cycles have no effect.
- Reset mid-frame: assert rst for 1 cycle after 2 data bits -> busy=0, no flags, dout_valid=0; the next full frame 4'hF (par 0) is received correctly.
